// File: rtl/ad7687_reader.sv
// ad7687_reader: CNV-triggered 16-bit SAR ADC reader (AD7687/AD7980 class, 3-wire, no busy indicator).
// Latency: start sampled at edge 0, valid rises at edge 1+CONV_CYCLES+QUIET_CYCLES+2*SCLK_DIV*DATA_WIDTH.
// Backpressure: one-word output register; an unaccepted word is overwritten and sets sticky overrun_o.
//
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   start_i                  conversion request, sampled only when idle
//   busy_o                   conversion in progress
//   data_o/valid_o/ready_i   captured word on a valid/ready stream
//   overrun_o/overrun_clr_i  sticky overwrite flag and its clear
//   cnv_o, sck_o, sdo_i      ADC convert-start, SPI clock (idle low), ADC serial data
module ad7687_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int SCLK_DIV     = 2,
    parameter int CONV_CYCLES  = 100,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    input  logic                  overrun_clr_i,
    output logic                  cnv_o,
    output logic                  sck_o,
    input  logic                  sdo_i
);

    localparam int CNT_MAX_A = (CONV_CYCLES > QUIET_CYCLES) ? CONV_CYCLES : QUIET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SCLK_DIV) ? CNT_MAX_A : SCLK_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BIT_W     = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    // QUIET also absorbs the hand-off cycle into READ, so its terminal count
    // is QUIET_CYCLES rather than QUIET_CYCLES-1.
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [BIT_W-1:0]      bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  cnv_q,     cnv_d;
    logic                  sck_q,     sck_d;
    logic                  busy_q,    busy_d;
    logic                  valid_q,   valid_d;
    logic                  overrun_q, overrun_d;
    logic                  word_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        cnv_d     = cnv_q;
        sck_d     = sck_q;
        busy_d    = busy_q;
        word_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                    cnv_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_QUIET;
                    cnt_d   = '0;
                    cnv_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // READ: low phase then high phase per bit; sample on the rising edge.
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shift_d = {shift_q[DATA_WIDTH-2:0], sdo_i};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            word_done = 1'b1;
                            state_d   = S_IDLE;
                            busy_d    = 1'b0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Output stream: a completing word always loads; it only drops valid
    // when the current word is accepted and nothing new arrives.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (word_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // Set has priority over clear.
        if (word_done && valid_q && !ready_i) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            cnv_q     <= 1'b0;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            cnv_q     <= cnv_d;
            sck_q     <= sck_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy_o    = busy_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign cnv_o     = cnv_q;
    assign sck_o     = sck_q;

endmodule
